usb_cdc_stream_ahbl: RTL



---
 rtl/usb_cdc_stream_ahbl.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_cdc_stream_ahbl.sv
`default_nettype none
// ============================================================================
// Module   : usb_cdc_stream_ahbl
// Function : AHB-Lite register front-end for the USB CDC byte-stream core
//            (TX/RX FWFT FIFOs, TX stall, flush, IRQs; RX idle timeout when
//            USB_CDC_AHBL_RXTO_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module usb_cdc_stream_ahbl #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int RXTO_W        = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic        en_o,
    output logic        irq
);

    localparam int c_TXP = TX_DEPTH_LOG2 + 1;
    localparam int c_RXP = RX_DEPTH_LOG2 + 1;

    localparam logic [15:0] c_A_TXDATA  = 16'h0000;
    localparam logic [15:0] c_A_RXDATA  = 16'h0004;
    localparam logic [15:0] c_A_TXLEVEL = 16'h0008;
    localparam logic [15:0] c_A_RXLEVEL = 16'h000C;
    localparam logic [15:0] c_A_TXFIFOT = 16'h0010;
    localparam logic [15:0] c_A_RXFIFOT = 16'h0014;
    localparam logic [15:0] c_A_CONTROL = 16'h0018;
    localparam logic [15:0] c_A_RXTO    = 16'h001C;
    localparam logic [15:0] c_A_IM      = 16'hFF00;
    localparam logic [15:0] c_A_MIS     = 16'hFF04;
    localparam logic [15:0] c_A_RIS     = 16'hFF08;
    localparam logic [15:0] c_A_ICR     = 16'hFF0C;

`ifdef USB_CDC_AHBL_RXTO_EN
    localparam logic [8:0] c_IRQ_MASK = 9'h1FF;
`else
    localparam logic [8:0] c_IRQ_MASK = 9'h1BF;
`endif

    // ------------------------------------------------------------------
    // Address phase capture
    // ------------------------------------------------------------------
    logic        r_hsel;
    logic        r_hwrite;
    logic        r_htrans1;
    logic [15:0] r_haddr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hsel    <= 1'b0;
            r_hwrite  <= 1'b0;
            r_htrans1 <= 1'b0;
            r_haddr   <= 16'h0000;
        end else if (HREADY) begin
            r_hsel    <= HSEL;
            r_hwrite  <= HWRITE;
            r_htrans1 <= HTRANS[1];
            r_haddr   <= HADDR[15:0];
        end
    end

    logic w_dphase;
    logic w_wr;
    logic w_rd;
    assign w_dphase = r_hsel & r_htrans1;
    assign w_wr     = w_dphase & r_hwrite;
    assign w_rd     = w_dphase & ~r_hwrite;

    logic w_wr_txdata, w_wr_txfifot, w_wr_rxfifot, w_wr_control;
    logic w_wr_im, w_wr_icr, w_rd_rxdata;
    assign w_wr_txdata  = w_wr & (r_haddr == c_A_TXDATA);
    assign w_wr_txfifot = w_wr & (r_haddr == c_A_TXFIFOT);
    assign w_wr_rxfifot = w_wr & (r_haddr == c_A_RXFIFOT);
    assign w_wr_control = w_wr & (r_haddr == c_A_CONTROL);
    assign w_wr_im      = w_wr & (r_haddr == c_A_IM);
    assign w_wr_icr     = w_wr & (r_haddr == c_A_ICR);
    assign w_rd_rxdata  = w_rd & (r_haddr == c_A_RXDATA);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic             r_en;
    logic             r_stall;
    logic [c_TXP-1:0] r_txfifot;
    logic [c_RXP-1:0] r_rxfifot;
    logic [8:0]       r_im;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_en      <= 1'b0;
            r_stall   <= 1'b0;
            r_txfifot <= '0;
            r_rxfifot <= '0;
            r_im      <= 9'h000;
        end else begin
            if (w_wr_control) begin
                r_en    <= HWDATA[0];
                r_stall <= HWDATA[1];
            end
            if (w_wr_txfifot) r_txfifot <= HWDATA[c_TXP-1:0];
            if (w_wr_rxfifot) r_rxfifot <= HWDATA[c_RXP-1:0];
            if (w_wr_im)      r_im      <= HWDATA[8:0] & c_IRQ_MASK;
        end
    end

    logic w_tx_flush;
    logic w_rx_flush;
    assign w_tx_flush = w_wr_control & HWDATA[2];
    assign w_rx_flush = w_wr_control & HWDATA[3];

    // ------------------------------------------------------------------
    // TX FIFO (FWFT, extra-bit pointers)
    // ------------------------------------------------------------------
    logic [7:0]       r_tx_mem [0:(1<<TX_DEPTH_LOG2)-1];
    logic [c_TXP-1:0] r_tx_wptr;
    logic [c_TXP-1:0] r_tx_rptr;
    logic [c_TXP-1:0] w_tx_level;
    logic             w_tx_empty, w_tx_full, w_tx_pop, w_tx_push;
    logic             w_tx_room, w_tx_stall, w_tx_ovf;

    assign w_tx_level = r_tx_wptr - r_tx_rptr;
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = ((r_tx_wptr ^ r_tx_rptr) == {1'b1, {TX_DEPTH_LOG2{1'b0}}});
    assign tx_tvalid  = r_en & ~w_tx_empty;
    assign tx_tdata   = r_tx_mem[r_tx_rptr[TX_DEPTH_LOG2-1:0]];
    assign w_tx_pop   = tx_tvalid & tx_tready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_tx_room  = ~w_tx_full | w_tx_pop;
    assign w_tx_push  = w_wr_txdata & w_tx_room;
    assign w_tx_stall = w_wr_txdata & r_stall & ~w_tx_room;
    assign w_tx_ovf   = w_wr_txdata & ~r_stall & ~w_tx_room;
    assign HREADYOUT  = ~w_tx_stall;

    always_ff @(posedge HCLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr[TX_DEPTH_LOG2-1:0]] <= HWDATA[7:0];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else if (w_tx_flush) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_TXP'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_TXP'(1);
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (FWFT, no empty bypass)
    // ------------------------------------------------------------------
    logic [7:0]       r_rx_mem [0:(1<<RX_DEPTH_LOG2)-1];
    logic [c_RXP-1:0] r_rx_wptr;
    logic [c_RXP-1:0] r_rx_rptr;
    logic [c_RXP-1:0] w_rx_level;
    logic [7:0]       w_rx_head;
    logic             w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_udf;

    assign w_rx_level = r_rx_wptr - r_rx_rptr;
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = ((r_rx_wptr ^ r_rx_rptr) == {1'b1, {RX_DEPTH_LOG2{1'b0}}});
    assign w_rx_head  = r_rx_mem[r_rx_rptr[RX_DEPTH_LOG2-1:0]];
    assign rx_tready  = r_en & ~w_rx_full;
    assign w_rx_push  = rx_tvalid & rx_tready;
    assign w_rx_pop   = w_rd_rxdata & ~w_rx_empty;
    assign w_rx_udf   = w_rd_rxdata & w_rx_empty;

    always_ff @(posedge HCLK) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr[RX_DEPTH_LOG2-1:0]] <= rx_tdata;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else if (w_rx_flush) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_RXP'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_RXP'(1);
        end
    end

    // ------------------------------------------------------------------
    // RX idle timeout
    // ------------------------------------------------------------------
    logic        w_to_hit;
    logic [31:0] w_rxto_rd;

`ifdef USB_CDC_AHBL_RXTO_EN
    logic [RXTO_W-1:0] r_rxto;
    logic [RXTO_W-1:0] r_rxto_cnt;
    logic              w_to_clr, w_to_inc;

    assign w_to_clr  = w_rx_push | w_rx_pop | w_rx_flush;
    assign w_to_inc  = r_en & ~w_rx_empty & (r_rxto != '0) & (r_rxto_cnt < r_rxto);
    // Fires only on the step that lands on RXTO; the counter then parks there.
    assign w_to_hit  = ~w_to_clr & w_to_inc & ((r_rxto_cnt + RXTO_W'(1)) == r_rxto);
    assign w_rxto_rd = 32'(r_rxto);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rxto     <= '0;
            r_rxto_cnt <= '0;
        end else begin
            if (w_wr & (r_haddr == c_A_RXTO)) r_rxto <= HWDATA[RXTO_W-1:0];
            if (w_to_clr)      r_rxto_cnt <= '0;
            else if (w_to_inc) r_rxto_cnt <= r_rxto_cnt + RXTO_W'(1);
        end
    end
`else
    logic [RXTO_W-1:0] w_rxto_unused;
    assign w_rxto_unused = '0;
    assign w_to_hit      = 1'b0;
    assign w_rxto_rd     = 32'h0;
`endif

    // ------------------------------------------------------------------
    // Interrupt status
    // ------------------------------------------------------------------
    logic [8:0] r_ris;
    logic [8:0] w_ris_set;
    logic [8:0] w_icr;
    logic       w_tx_below, w_rx_above;

    assign w_tx_below = (w_tx_level < r_txfifot);
    assign w_rx_above = (w_rx_level > r_rxfifot);
    assign w_ris_set  = {w_rx_udf, w_tx_ovf, w_to_hit, w_tx_full, w_rx_empty,
                         w_rx_above, w_rx_full, w_tx_below, w_tx_empty};
    assign w_icr      = w_wr_icr ? HWDATA[8:0] : 9'h000;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_ris <= 9'h000;
        else          r_ris <= ((r_ris & ~w_icr) | w_ris_set) & c_IRQ_MASK;
    end

    assign irq  = |(r_ris & r_im);
    assign en_o = r_en;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        HRDATA = 32'hDEADBEEF;
        case (r_haddr)
            c_A_TXDATA:  HRDATA = 32'h0;
            c_A_RXDATA:  HRDATA = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            c_A_TXLEVEL: HRDATA = 32'(w_tx_level);
            c_A_RXLEVEL: HRDATA = 32'(w_rx_level);
            c_A_TXFIFOT: HRDATA = 32'(r_txfifot);
            c_A_RXFIFOT: HRDATA = 32'(r_rxfifot);
            c_A_CONTROL: HRDATA = {30'h0, r_stall, r_en};
            c_A_RXTO:    HRDATA = w_rxto_rd;
            c_A_IM:      HRDATA = {23'h0, r_im};
            c_A_MIS:     HRDATA = {23'h0, r_ris & r_im};
            c_A_RIS:     HRDATA = {23'h0, r_ris};
            c_A_ICR:     HRDATA = 32'h0;
            default:     HRDATA = 32'hDEADBEEF;
        endcase
    end

    logic w_unused;
    assign w_unused = &{1'b0, HSIZE, HADDR[31:16], HTRANS[0], HWDATA};

endmodule
`default_nettype wire
